alu_wb_buffer: RTL and testbench
================================

// Module: alu_wb_buffer
// PURPOSE
//  Result queue directly downstream of the 2nd-cycle ALU output register. Captures each completed
//  ALU packet (rd/rob tags, result, cmp, branch/jump info, exception) exactly once and replays it
//  to the writeback/ROB-complete port under valid/ready. Back-pressures the ALU via stall_o.
// PARAMETERS
//  XLEN                 64  datapath width
//  PHY_REG_ADDR_WIDTH    6  physical register tag width
//  ROB_INDEX_WIDTH       5  ROB index width
//  VIRTUAL_ADDR_LEN     39  pc width
//  EXCEPTION_CODE_WIDTH  4  ecause width
//  DEPTH                 4  queue entries, power of two, >= 2
// PORTS
//  clk           in   1     clock
//  rstn          in   1     synchronous, active-low reset
//  flush         in   1     pipeline flush, drops all queued and incoming packets
//  done_i        in   1     ALU output valid (held while ALU stalled)
//  rd_addr_i     in   PHY_REG_ADDR_WIDTH  destination tag
//  rob_index_i   in   ROB_INDEX_WIDTH     ROB index
//  alu_result_i  in   XLEN  ALU result
//  cmp_result_i  in   1     compare result
//  jump_i/branch_i in 1     control-flow flags
//  pc_i, next_pc_i in VIRTUAL_ADDR_LEN    pc / predicted next pc
//  exception_valid_i in 1, ecause_i in EXCEPTION_CODE_WIDTH  exception info
//  stall_o       out  1     stall to ALU (ALU ready = ~stall_o)
//  wb_valid_o    out  1     head packet valid
//  wb_ready_i    in   1     writeback accepts head
//  wb_rd_we_o    out  1     register write enable = head valid & ~head exception
//  wb_* outputs  out  -     head copies of every *_i payload field above (same widths)
//  count_o       out  log2(DEPTH)+1  occupancy
//  overflow_o    out  1     sticky: push attempted while full
// BEHAVIOUR
//  - Reset (!rstn at posedge): count=0, rd/wr ptrs=0, stall_q=0, overflow_o=0; all wb_* payload
//    outputs read 0 (storage cleared), wb_valid_o=0, stall_o=0.
//  - stall_q: register of stall_o from previous cycle. ALU loads a new packet only on edges where
//    stall_o was 0, so push = done_i & ~stall_q (held packets never pushed twice).
//  - pop = wb_valid_o & wb_ready_i; wb_valid_o = (count != 0). Outputs come from head entry
//    storage; no same-cycle bypass: push at cycle t is visible on wb_* at t+1 earliest.
//  - stall_o = (count >= DEPTH-1), from registered count only (no comb path from wb_ready_i).
//    Guarantees the one packet in flight during the stall-response cycle always fits.
//  - Simultaneous push & pop: both occur, count unchanged, wr/rd ptrs advance.
//  - Push while full (only on protocol violation): packet dropped, overflow_o set until reset.
//  - Pointers wrap modulo DEPTH; count range 0..DEPTH.
//  - flush (priority over push/pop, below reset): count=0, ptrs=0, stall_q=0, same-cycle push
//    and pop discarded; wb_valid_o=0 next cycle; overflow_o unaffected.
//  - wb_rd_we_o = wb_valid_o & ~wb_exception_valid_o; exception packets still pop normally.
// TESTING
//  1 Reset, single push rd=5 rob=3 result=0x2A, wb_ready_i=1 -> wb_valid_o=1 one cycle later with
//    rd=5/rob=3/result=0x2A, wb_rd_we_o=1, count returns to 0.
//  2 wb_ready_i=0, push 4 back-to-back (DEPTH=4) -> stall_o rises when count=3, 4th in-flight
//    packet accepted, count=4, no overflow; done_i held high 3 more cycles -> count stays 4.
//  3 Full queue, wb_ready_i=1 with continuous pushes -> push/pop same cycle, FIFO order kept
//    across pointer wrap (results 1..10 emerge in order).
//  4 flush with count=3 and push present -> next cycle count=0, wb_valid_o=0, pushed packet lost.
//  5 Push with exception_valid_i=1 ecause=2 -> wb_valid_o=1, wb_rd_we_o=0, wb_ecause_o=2.
//  6 Force push when full with stall_q=0 -> overflow_o=1 sticky, queued data intact.

Source files
------------

// File: rtl/alu_wb_buffer.sv
// Result queue between the ALU output register and the writeback/ROB-complete port.
// Each completed ALU packet is captured once and replayed under valid/ready. stall_o back-pressures the ALU.
module alu_wb_buffer #(
  parameter int XLEN                 = 64,
  parameter int PHY_REG_ADDR_WIDTH   = 6,
  parameter int ROB_INDEX_WIDTH      = 5,
  parameter int VIRTUAL_ADDR_LEN     = 39,
  parameter int EXCEPTION_CODE_WIDTH = 4,
  parameter int DEPTH                = 4
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic                            flush,
  input  logic                            done_i,
  input  logic [PHY_REG_ADDR_WIDTH-1:0]   rd_addr_i,
  input  logic [ROB_INDEX_WIDTH-1:0]      rob_index_i,
  input  logic [XLEN-1:0]                 alu_result_i,
  input  logic                            cmp_result_i,
  input  logic                            jump_i,
  input  logic                            branch_i,
  input  logic [VIRTUAL_ADDR_LEN-1:0]     pc_i,
  input  logic [VIRTUAL_ADDR_LEN-1:0]     next_pc_i,
  input  logic                            exception_valid_i,
  input  logic [EXCEPTION_CODE_WIDTH-1:0] ecause_i,
  output logic                            stall_o,
  output logic                            wb_valid_o,
  input  logic                            wb_ready_i,
  output logic                            wb_rd_we_o,
  output logic [PHY_REG_ADDR_WIDTH-1:0]   wb_rd_addr_o,
  output logic [ROB_INDEX_WIDTH-1:0]      wb_rob_index_o,
  output logic [XLEN-1:0]                 wb_alu_result_o,
  output logic                            wb_cmp_result_o,
  output logic                            wb_jump_o,
  output logic                            wb_branch_o,
  output logic [VIRTUAL_ADDR_LEN-1:0]     wb_pc_o,
  output logic [VIRTUAL_ADDR_LEN-1:0]     wb_next_pc_o,
  output logic                            wb_exception_valid_o,
  output logic [EXCEPTION_CODE_WIDTH-1:0] wb_ecause_o,
  output logic [$clog2(DEPTH):0]          count_o,
  output logic                            overflow_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int PW    = PHY_REG_ADDR_WIDTH + ROB_INDEX_WIDTH + XLEN + 3
                       + 2 * VIRTUAL_ADDR_LEN + 1 + EXCEPTION_CODE_WIDTH;

  logic [PW-1:0]    mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_nxt_s;
  logic             stall_q_r;
  logic             overflow_r;
  logic             push_s;
  logic             pop_s;
  logic             full_s;
  logic             push_ok_s;
  logic [PW-1:0]    din_s;
  logic [PW-1:0]    head_s;

  assign din_s = {rd_addr_i, rob_index_i, alu_result_i, cmp_result_i, jump_i, branch_i,
                  pc_i, next_pc_i, exception_valid_i, ecause_i};
  assign head_s = mem_r[rd_ptr_r];

  assign {wb_rd_addr_o, wb_rob_index_o, wb_alu_result_o, wb_cmp_result_o, wb_jump_o, wb_branch_o,
          wb_pc_o, wb_next_pc_o, wb_exception_valid_o, wb_ecause_o} = head_s;

  // Stall from registered occupancy only, leaving room for the packet already in flight.
  assign stall_o    = (count_r >= CNT_W'(DEPTH - 1));
  assign wb_valid_o = (count_r != {CNT_W{1'b0}});
  assign wb_rd_we_o = wb_valid_o & ~wb_exception_valid_o;
  assign count_o    = count_r;
  assign overflow_o = overflow_r;

  // Handshake decode and next occupancy.
  always_comb begin
    push_s      = done_i & ~stall_q_r;
    pop_s       = wb_valid_o & wb_ready_i;
    full_s      = (count_r == CNT_W'(DEPTH));
    push_ok_s   = push_s & ~full_s;
    count_nxt_s = count_r;
    case ({push_ok_s, pop_s})
      2'b10:   count_nxt_s = count_r + CNT_W'(1);
      2'b01:   count_nxt_s = count_r - CNT_W'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Queue state, storage and sticky overflow; flush clears occupancy but keeps overflow.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_r   <= {PTR_W{1'b0}};
      rd_ptr_r   <= {PTR_W{1'b0}};
      count_r    <= {CNT_W{1'b0}};
      stall_q_r  <= 1'b0;
      overflow_r <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {PW{1'b0}};
      end
    end else if (flush) begin
      wr_ptr_r  <= {PTR_W{1'b0}};
      rd_ptr_r  <= {PTR_W{1'b0}};
      count_r   <= {CNT_W{1'b0}};
      stall_q_r <= 1'b0;
    end else begin
      stall_q_r <= stall_o;
      count_r   <= count_nxt_s;
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= din_s;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      if (push_s && full_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_wb_buffer.sv
// Scoreboard bench for alu_wb_buffer: the bench plays the ALU (holds its packet while stalled)
// and every popped head packet is compared against the oldest expected packet.
module tb_alu_wb_buffer;

  typedef struct packed {
    logic [5:0]  rd;
    logic [4:0]  rob;
    logic [63:0] result;
    logic        cmp;
    logic        jump;
    logic        branch;
    logic [38:0] pc;
    logic [38:0] npc;
    logic        exc;
    logic [3:0]  ecause;
  } pkt_t;

  logic        clk = 1'b0;
  logic        rstn, flush, done_i, wb_ready_i;
  logic [5:0]  rd_addr_i;
  logic [4:0]  rob_index_i;
  logic [63:0] alu_result_i;
  logic        cmp_result_i, jump_i, branch_i, exception_valid_i;
  logic [38:0] pc_i, next_pc_i;
  logic [3:0]  ecause_i;
  logic        stall_o, wb_valid_o, wb_rd_we_o, wb_cmp_result_o, wb_jump_o, wb_branch_o;
  logic        wb_exception_valid_o, overflow_o;
  logic [5:0]  wb_rd_addr_o;
  logic [4:0]  wb_rob_index_o;
  logic [63:0] wb_alu_result_o;
  logic [38:0] wb_pc_o, wb_next_pc_o;
  logic [3:0]  wb_ecause_o;
  logic [2:0]  count_o;

  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_popped = 0;
  bit   saw_both = 1'b0;
  logic tb_stall_q = 1'b0;
  pkt_t q[$];

  alu_wb_buffer dut (
    .clk(clk), .rstn(rstn), .flush(flush), .done_i(done_i),
    .rd_addr_i(rd_addr_i), .rob_index_i(rob_index_i), .alu_result_i(alu_result_i),
    .cmp_result_i(cmp_result_i), .jump_i(jump_i), .branch_i(branch_i),
    .pc_i(pc_i), .next_pc_i(next_pc_i),
    .exception_valid_i(exception_valid_i), .ecause_i(ecause_i),
    .stall_o(stall_o), .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i), .wb_rd_we_o(wb_rd_we_o),
    .wb_rd_addr_o(wb_rd_addr_o), .wb_rob_index_o(wb_rob_index_o), .wb_alu_result_o(wb_alu_result_o),
    .wb_cmp_result_o(wb_cmp_result_o), .wb_jump_o(wb_jump_o), .wb_branch_o(wb_branch_o),
    .wb_pc_o(wb_pc_o), .wb_next_pc_o(wb_next_pc_o),
    .wb_exception_valid_o(wb_exception_valid_o), .wb_ecause_o(wb_ecause_o),
    .count_o(count_o), .overflow_o(overflow_o)
  );

  always #5 clk = ~clk;

  function automatic pkt_t mk(input int n);
    pkt_t p;
    p.rd     = 6'(n);
    p.rob    = 5'(n + 3);
    p.result = 64'(n);
    p.cmp    = n[0];
    p.jump   = n[1];
    p.branch = n[2];
    p.pc     = 39'(n * 4);
    p.npc    = 39'(n * 4 + 4);
    p.exc    = 1'b0;
    p.ecause = 4'd0;
    return p;
  endfunction

  function automatic pkt_t head();
    return {wb_rd_addr_o, wb_rob_index_o, wb_alu_result_o, wb_cmp_result_o, wb_jump_o, wb_branch_o,
            wb_pc_o, wb_next_pc_o, wb_exception_valid_o, wb_ecause_o};
  endfunction

  task automatic set_inputs(input pkt_t p);
    rd_addr_i = p.rd; rob_index_i = p.rob; alu_result_i = p.result;
    cmp_result_i = p.cmp; jump_i = p.jump; branch_i = p.branch;
    pc_i = p.pc; next_pc_i = p.npc; exception_valid_i = p.exc; ecause_i = p.ecause;
  endtask

  // One clock of ALU model + scoreboard pop check; ends #1 after the rising edge.
  task automatic drive_cycle(input logic ready, input bit have_new, input pkt_t p, output bit took);
    pkt_t got;
    took = 1'b0;
    wb_ready_i = ready;
    if (!tb_stall_q) begin
      if (have_new) begin
        set_inputs(p);
        done_i = 1'b1;
        took = 1'b1;
        if (!flush) q.push_back(p);
      end else begin
        done_i = 1'b0;
      end
    end
    if (wb_valid_o && ready && !flush) begin
      got = head();
      n_checks++;
      if (q.size() == 0) begin
        $display("FAIL pop_unexpected: got result %0h, required no valid output", got.result);
      end else if (got !== q[0]) begin
        $display("FAIL pop_payload: got %h, required %h", got, q[0]);
        void'(q.pop_front());
      end else begin
        n_pass++;
        void'(q.pop_front());
      end
      n_popped++;
      if (took) saw_both = 1'b1;
    end
    tb_stall_q = flush ? 1'b0 : stall_o;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h, required %0h", name, got, exp);
    else n_pass++;
  endtask

  task automatic drain(input string name);
    bit t;
    for (int i = 0; i < 20 && q.size() != 0; i++) drive_cycle(1'b1, 1'b0, mk(0), t);
    chk({name, "_sb_empty"}, 64'(q.size()), 64'd0);
    chk({name, "_count0"}, 64'(count_o), 64'd0);
  endtask

  task automatic test_reset();
    rstn = 1'b0; flush = 1'b0; done_i = 1'b0; wb_ready_i = 1'b0;
    set_inputs(mk(0));
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    tb_stall_q = 1'b0;
    q.delete();
    @(posedge clk);
    #1;
    chk("rst_count", 64'(count_o), 64'd0);
    chk("rst_valid", 64'(wb_valid_o), 64'd0);
    chk("rst_stall", 64'(stall_o), 64'd0);
    chk("rst_overflow", 64'(overflow_o), 64'd0);
    chk("rst_result", wb_alu_result_o, 64'd0);
    chk("rst_rd", 64'(wb_rd_addr_o), 64'd0);
  endtask

  task automatic test_single();
    pkt_t p;
    bit t;
    p = mk(1);
    p.rd = 6'd5; p.rob = 5'd3; p.result = 64'h2A;
    drive_cycle(1'b1, 1'b1, p, t);
    chk("single_valid", 64'(wb_valid_o), 64'd1);
    chk("single_rd", 64'(wb_rd_addr_o), 64'd5);
    chk("single_rob", 64'(wb_rob_index_o), 64'd3);
    chk("single_result", wb_alu_result_o, 64'h2A);
    chk("single_we", 64'(wb_rd_we_o), 64'd1);
    drive_cycle(1'b1, 1'b0, mk(0), t);
    chk("single_count0", 64'(count_o), 64'd0);
    chk("single_popped", 64'(n_popped), 64'd1);
  endtask

  task automatic test_back_to_back();
    bit t;
    n_popped = 0;
    for (int n = 1; n <= 4; n++) begin
      drive_cycle(1'b0, 1'b1, mk(n), t);
      chk("b2b_took", 64'(t), 64'd1);
      if (n == 2) chk("b2b_stall_at2", 64'(stall_o), 64'd0);
      if (n == 3) chk("b2b_stall_at3", 64'(stall_o), 64'd1);
    end
    chk("b2b_count4", 64'(count_o), 64'd4);
    chk("b2b_no_overflow", 64'(overflow_o), 64'd0);
    for (int i = 0; i < 3; i++) drive_cycle(1'b0, 1'b1, mk(5), t);
    chk("b2b_held_count", 64'(count_o), 64'd4);
    chk("b2b_held_overflow", 64'(overflow_o), 64'd0);
  endtask

  task automatic test_wrap();
    bit t;
    int n = 5;
    saw_both = 1'b0;
    for (int i = 0; i < 60 && (n <= 10 || q.size() != 0); i++) begin
      drive_cycle(1'b1, n <= 10, mk(n), t);
      if (t) n++;
    end
    drive_cycle(1'b1, 1'b0, mk(0), t);
    chk("wrap_all_popped", 64'(n_popped), 64'd10);
    chk("wrap_push_pop_same_cycle", 64'(saw_both), 64'd1);
    chk("wrap_count0", 64'(count_o), 64'd0);
  endtask

  task automatic test_flush();
    bit t;
    for (int n = 20; n <= 22; n++) drive_cycle(1'b0, 1'b1, mk(n), t);
    chk("flush_pre_count", 64'(count_o), 64'd3);
    flush = 1'b1;
    drive_cycle(1'b0, 1'b1, mk(23), t);
    flush = 1'b0;
    q.delete();
    chk("flush_count", 64'(count_o), 64'd0);
    chk("flush_valid", 64'(wb_valid_o), 64'd0);
    chk("flush_stall", 64'(stall_o), 64'd0);
    drive_cycle(1'b1, 1'b0, mk(0), t);
    chk("flush_lost_count", 64'(count_o), 64'd0);
  endtask

  task automatic test_exception();
    pkt_t p;
    bit t;
    p = mk(40);
    p.exc = 1'b1; p.ecause = 4'd2;
    drive_cycle(1'b0, 1'b1, p, t);
    chk("exc_valid", 64'(wb_valid_o), 64'd1);
    chk("exc_we", 64'(wb_rd_we_o), 64'd0);
    chk("exc_ecause", 64'(wb_ecause_o), 64'd2);
    drain("exc");
  endtask

  task automatic test_overflow();
    bit t;
    for (int n = 30; n <= 33; n++) drive_cycle(1'b0, 1'b1, mk(n), t);
    drive_cycle(1'b0, 1'b0, mk(0), t);
    chk("ovf_full", 64'(count_o), 64'd4);
    force dut.stall_q_r = 1'b0;
    set_inputs(mk(34));
    done_i = 1'b1;
    @(posedge clk);
    #1;
    release dut.stall_q_r;
    done_i = 1'b0;
    chk("ovf_set", 64'(overflow_o), 64'd1);
    chk("ovf_count", 64'(count_o), 64'd4);
    tb_stall_q = stall_o;
    repeat (2) drive_cycle(1'b0, 1'b0, mk(0), t);
    chk("ovf_sticky", 64'(overflow_o), 64'd1);
    drain("ovf");
    chk("ovf_sticky_after_drain", 64'(overflow_o), 64'd1);
    test_reset();
    chk("ovf_cleared_by_reset", 64'(overflow_o), 64'd0);
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_wrap();
    test_flush();
    test_exception();
    test_overflow();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
